// File: rtl/c3lib_strap_pkg.sv
// Shared types and constants for the strap capture cell.
// Optional re-capture support is enabled with C3LIB_STRAP_RECAP_EN.
package c3lib_strap_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SETTLE,
    ST_LOCKED
  } strap_st_t;

  // Edges spent letting the sync/compare pipeline fill after reset
  localparam int unsigned FILL_CYC = 3;

  // Counter must hold both the fill count and the filter count
  function automatic int unsigned cnt_width(input int unsigned filt);
    int unsigned w;
    int unsigned fw;
    w  = (filt > 32'd1) ? 32'($clog2(filt)) : 32'd1;
    fw = 32'($clog2(FILL_CYC));
    if (w < fw) begin
      w = fw;
    end
    return w;
  endfunction

endpackage

// File: rtl/c3lib_strap_sync.sv
// WIDTH-wide two-flop synchronizer for asynchronous strap inputs.
module c3lib_strap_sync
  import c3lib_strap_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/c3lib_strap_capture_lcell.sv
// Synchronizes, filters and latches static strap inputs; flags later disagreement.
// Define C3LIB_STRAP_RECAP_EN to allow recap_req to re-run the filter from LOCKED.
module c3lib_strap_capture_lcell
  import c3lib_strap_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      FILT_CYC = 16,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             recap_req,
  output logic [WIDTH-1:0] strap_out,
  output logic             strap_vld,
  output logic             strap_mism,
  output logic             strap_err
);

  localparam int unsigned CNT_W = cnt_width(FILT_CYC);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  strap_st_t        state;
  strap_st_t        state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             vld_nxt;
  logic             mism_nxt;
  logic             err_nxt;

  c3lib_strap_sync #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (strap_in),
    .q     (s2)
  );

`ifndef C3LIB_STRAP_RECAP_EN
  logic unused_recap;
  assign unused_recap = recap_req;
`endif

  // State, counter, compare stage and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      cnt        <= '0;
      s3         <= RST_VAL;
      strap_out  <= RST_VAL;
      strap_vld  <= 1'b0;
      strap_mism <= 1'b0;
      strap_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      s3         <= s2;
      strap_out  <= out_nxt;
      strap_vld  <= vld_nxt;
      strap_mism <= mism_nxt;
      strap_err  <= err_nxt;
    end
  end

  // Next-state and next-output logic; mism is forced low outside LOCKED
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = strap_out;
    vld_nxt   = strap_vld;
    mism_nxt  = 1'b0;
    err_nxt   = strap_err;

    case (state)
      ST_FILL: begin
        if (cnt == CNT_W'(FILL_CYC - 1)) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_SETTLE: begin
        if (s2 != s3) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(FILT_CYC - 1)) begin
          state_nxt = ST_LOCKED;
          cnt_nxt   = '0;
          out_nxt   = s2;
          vld_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_LOCKED: begin
        mism_nxt = (s2 != strap_out);
        err_nxt  = strap_err | strap_mism;
`ifdef C3LIB_STRAP_RECAP_EN
        // strap_out holds the old value until the relock
        if (recap_req) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
          vld_nxt   = 1'b0;
          mism_nxt  = 1'b0;
        end
`endif
      end

      default: begin
        state_nxt = ST_FILL;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
